alu_op_driver: RTL and testbench
================================

// Module: alu_op_driver
// PURPOSE
//  Sequential initiator for the 4-bit combinational arithmetic device (in1/in2/opcode -> out).
//  Accepts operand commands over valid/ready, drives them onto the device inputs and waits a settle time.
//  Samples the device output and compares it to an internally computed expected value.
//  Returns a response with a pass/fail flag; sits between the test/control logic and the device.
// PARAMETERS
//  DATA_W  4   operand width (cmd_in1/cmd_in2, dut_in1/dut_in2)
//  OUT_W   8   device result width
//  SETTLE  1   clock edges from drive to sample; legal range 1..15
//  CNT_W   16  width of pass/error counters
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       command accepted on edge with cmd_valid&cmd_ready
//  cmd_in1       in   DATA_W  operand A
//  cmd_in2       in   DATA_W  operand B
//  cmd_opcode    in   2       00 add, 01 sub, 10/11 reserved (driven, not checked)
//  dut_in1       out  DATA_W  registered drive to device in1
//  dut_in2       out  DATA_W  registered drive to device in2
//  dut_opcode    out  2       registered drive to device opcode
//  dut_out       in   OUT_W   device result
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       response consumed on edge with rsp_valid&rsp_ready
//  rsp_out       out  OUT_W   captured dut_out
//  rsp_expected  out  OUT_W   model result
//  rsp_checked   out  1       1 if opcode is add/sub
//  rsp_error     out  1       rsp_checked & (rsp_out != rsp_expected)
//  busy          out  1       state != IDLE
//  pass_cnt      out  CNT_W   checked responses without error, saturating
//  err_cnt       out  CNT_W   checked responses with error, saturating
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except cmd_ready=1. An in-flight command is dropped, counters cleared.
//  - FSM IDLE -> SETTLE -> RESP -> IDLE. One command in flight. cmd_ready=1 only in IDLE.
//  - IDLE: on accept edge E0, load dut_* from cmd_*. Load settle counter. Go to SETTLE.
//  - SETTLE: count edges. At edge E_SETTLE, capture dut_out->rsp_out and expected->rsp_expected.
//    Set rsp_checked/rsp_error. Update counters. Go to RESP; rsp_valid=1 from that edge.
//  - RESP: rsp_* stable while rsp_valid&!rsp_ready. On handshake edge, rsp_valid=0 and go to IDLE.
//  - Minimum command period is SETTLE+2 cycles.
//  - dut_* hold the last command after the response; they change only on accept or reset.
//  - Expected value: operands zero-extended to OUT_W. Add: in1+in2 (max 30).
//    Sub: (in1-in2) mod 2^OUT_W, e.g. 3-5 = 8'hFE. Reserved opcodes: expected=0, checked=0.
//  - Counters: +1 at capture edge when checked, pass or err per rsp_error; hold at all-ones.
//    Reserved opcodes touch neither counter.
//  - cmd_valid while busy is ignored; no reaction to cmd_* outside IDLE.
// STRUCTURE
//  - Package alu_drv_pkg: opcode enum (OP_ADD, OP_SUB, OP_RSV2, OP_RSV3).
//    Also: state enum (S_IDLE, S_SETTLE, S_RESP), function alu_expected(in1,in2,op).
//  - Sub-module sat_counter #(CNT_W): inc, clear -> count, saturating; instanced for pass and err.
// TESTING (bench uses a behavioural device model, optional fault injection out+1)
//  1. Reset held 3 cycles, then released -> all outputs 0, cmd_ready=1, busy=0.
//  2. cmd (4,3,00), SETTLE=1 -> dut_in1=4 after E0; rsp_valid after E1.
//     Expect rsp_out=7, rsp_expected=7, error=0, pass_cnt=1.
//  3. cmd (5,3,01) -> rsp_out=2, pass. Then (3,5,01) -> rsp_expected=8'hFE, pass; pass_cnt=2.
//  4. Fault model on, cmd (15,15,00) -> rsp_expected=8'h1E, rsp_out=8'h1F, rsp_error=1, err_cnt=1.
//  5. cmd (2,2,10), rsp_ready low 5 cycles -> rsp_checked=0, rsp_* stable.
//     cmd_ready=0 while waiting; counters unchanged.
//  6. SETTLE=3, reset asserted at 2nd edge after accept -> no rsp_valid, counters 0, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared types and the reference model for the ALU operand driver.
package alu_drv_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSV2 = 2'b10,
    OP_RSV3 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Widths of the model's operand and result buses; callers zero-extend
  // their operands into EXP_IN_W and truncate the result to their width,
  // which also yields the modulo behaviour for subtraction.
  localparam int unsigned EXP_IN_W  = 16;
  localparam int unsigned EXP_OUT_W = 32;

  // Reference result of the arithmetic device; reserved opcodes give 0.
  function automatic logic [EXP_OUT_W-1:0] alu_expected(
    input logic [EXP_IN_W-1:0] in1,
    input logic [EXP_IN_W-1:0] in2,
    input logic [1:0]          op
  );
    logic [EXP_OUT_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {16'd0, in1} + {16'd0, in2};
      OP_SUB:  r = {16'd0, in1} - {16'd0, in2};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_driver_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared synchronously.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/alu_op_driver.sv
// Sequential initiator for a 4-bit combinational arithmetic device: accepts a
// command, drives the device, waits SETTLE edges, samples and checks the result.
module alu_op_driver
  import alu_drv_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_in1,
  input  logic [DATA_W-1:0] cmd_in2,
  input  logic [1:0]        cmd_opcode,
  output logic [DATA_W-1:0] dut_in1,
  output logic [DATA_W-1:0] dut_in2,
  output logic [1:0]        dut_opcode,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_out,
  output logic [OUT_W-1:0]  rsp_expected,
  output logic              rsp_checked,
  output logic              rsp_error,
  output logic              busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // The settle counter holds "edges remaining minus one", so capture happens
  // exactly SETTLE edges after the accept edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [DATA_W-1:0] dut_in1_q, dut_in1_d;
  logic [DATA_W-1:0] dut_in2_q, dut_in2_d;
  logic [1:0]        dut_op_q, dut_op_d;
  logic [OUT_W-1:0]  rsp_out_q, rsp_out_d;
  logic [OUT_W-1:0]  rsp_exp_q, rsp_exp_d;
  logic              rsp_chk_q, rsp_chk_d;
  logic              rsp_err_q, rsp_err_d;

  logic [OUT_W-1:0]  exp_now;
  logic              chk_now;
  logic              err_now;
  logic              capture;
  logic              pass_inc;
  logic              err_inc;

  // Model result and verdict for the operands currently driven on the device.
  always_comb begin
    exp_now = OUT_W'(alu_expected(EXP_IN_W'(dut_in1_q), EXP_IN_W'(dut_in2_q), dut_op_q));
    chk_now = (dut_op_q == OP_ADD) || (dut_op_q == OP_SUB);
    err_now = chk_now && (dut_out != exp_now);
  end

  // FSM next-state, operand drive and response capture.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    dut_in1_d = dut_in1_q;
    dut_in2_d = dut_in2_q;
    dut_op_d  = dut_op_q;
    rsp_out_d = rsp_out_q;
    rsp_exp_d = rsp_exp_q;
    rsp_chk_d = rsp_chk_q;
    rsp_err_d = rsp_err_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dut_in1_d = cmd_in1;
          dut_in2_d = cmd_in2;
          dut_op_d  = cmd_opcode;
          settle_d  = SETTLE_LOAD;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          capture   = 1'b1;
          rsp_out_d = dut_out;
          rsp_exp_d = exp_now;
          rsp_chk_d = chk_now;
          rsp_err_d = err_now;
          state_d   = S_RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pass_inc = capture && chk_now && !err_now;
  assign err_inc  = capture && err_now;

  // State, drive and response registers; reset clears everything, dropping
  // any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      dut_in1_q <= '0;
      dut_in2_q <= '0;
      dut_op_q  <= '0;
      rsp_out_q <= '0;
      rsp_exp_q <= '0;
      rsp_chk_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      dut_in1_q <= dut_in1_d;
      dut_in2_q <= dut_in2_d;
      dut_op_q  <= dut_op_d;
      rsp_out_q <= rsp_out_d;
      rsp_exp_q <= rsp_exp_d;
      rsp_chk_q <= rsp_chk_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (pass_inc),
    .count (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign dut_in1      = dut_in1_q;
  assign dut_in2      = dut_in2_q;
  assign dut_opcode   = dut_op_q;
  assign rsp_out      = rsp_out_q;
  assign rsp_expected = rsp_exp_q;
  assign rsp_checked  = rsp_chk_q;
  assign rsp_error    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a behavioural arithmetic device.
module tb_alu_op_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;

  logic       rst = 1'b1;
  logic       rst3 = 1'b1;
  logic       fault = 1'b0;
  logic [3:0] cmd_in1 = '0;
  logic [3:0] cmd_in2 = '0;
  logic [1:0] cmd_opcode = '0;

  logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_checked, rsp_error, busy;
  logic [3:0]  dut_in1, dut_in2;
  logic [1:0]  dut_opcode;
  logic [7:0]  dut_out, rsp_out, rsp_expected;
  logic [15:0] pass_cnt, err_cnt;

  logic        cmd_valid_3 = 1'b0, rsp_ready_3 = 1'b0;
  logic        cmd_ready_3, rsp_valid_3, rsp_checked_3, rsp_error_3, busy_3;
  logic [3:0]  dut_in1_3, dut_in2_3;
  logic [1:0]  dut_opcode_3;
  logic [7:0]  dut_out_3, rsp_out_3, rsp_expected_3;
  logic [15:0] pass_cnt_3, err_cnt_3;

  // Behavioural device: add/sub in 8 bits, reserved opcodes concatenate.
  function automatic logic [7:0] dev(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {4'd0, a} + {4'd0, b};
      2'b01:   return {4'd0, a} - {4'd0, b};
      default: return {a, b};
    endcase
  endfunction

  assign dut_out   = dev(dut_in1, dut_in2, dut_opcode) + {7'd0, fault};
  assign dut_out_3 = dev(dut_in1_3, dut_in2_3, dut_opcode_3);

  alu_op_driver #(.DATA_W(4), .OUT_W(8), .SETTLE(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_opcode(cmd_opcode),
    .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_opcode(dut_opcode), .dut_out(dut_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_expected(rsp_expected), .rsp_checked(rsp_checked), .rsp_error(rsp_error),
    .busy(busy), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  alu_op_driver #(.DATA_W(4), .OUT_W(8), .SETTLE(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst3), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_opcode(cmd_opcode),
    .dut_in1(dut_in1_3), .dut_in2(dut_in2_3), .dut_opcode(dut_opcode_3), .dut_out(dut_out_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_out(rsp_out_3),
    .rsp_expected(rsp_expected_3), .rsp_checked(rsp_checked_3), .rsp_error(rsp_error_3),
    .busy(busy_3), .pass_cnt(pass_cnt_3), .err_cnt(err_cnt_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command to the SETTLE=1 instance for one edge (the accept edge).
  task automatic accept1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    cmd_in1 = a; cmd_in2 = b; cmd_opcode = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Consume the pending response of the SETTLE=1 instance.
  task automatic handshake1();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_n++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL handshake: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); else pass_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    repeat (3) tick();
    rst = 1'b0; rst3 = 1'b0;
    tick();
    total_n++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_n++;
    total_n++; if ({rsp_valid, rsp_checked, rsp_error} !== 3'b000) $display("FAIL reset_rsp_flags: got %b want 000", {rsp_valid, rsp_checked, rsp_error}); else pass_n++;
    total_n++; if ({rsp_out, rsp_expected} !== 16'h0000) $display("FAIL reset_rsp_data: got %h want 0000", {rsp_out, rsp_expected}); else pass_n++;
    total_n++; if ({dut_in1, dut_in2, dut_opcode} !== 10'd0) $display("FAIL reset_dut_drive: got %h want 0", {dut_in1, dut_in2, dut_opcode}); else pass_n++;
    total_n++; if ({pass_cnt, err_cnt} !== 32'd0) $display("FAIL reset_counters: got %h want 0", {pass_cnt, err_cnt}); else pass_n++;
    total_n++; if (cmd_ready_3 !== 1'b1 || busy_3 !== 1'b0) $display("FAIL reset_inst3: cmd_ready=%b busy=%b want 1/0", cmd_ready_3, busy_3); else pass_n++;
  endtask

  task automatic test_add();
    accept1(4'd4, 4'd3, 2'b00);
    total_n++; if (dut_in1 !== 4'd4 || dut_in2 !== 4'd3) $display("FAIL add_drive: got %0d,%0d want 4,3", dut_in1, dut_in2); else pass_n++;
    total_n++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL add_e0_state: valid=%b busy=%b ready=%b want 0/1/0", rsp_valid, busy, cmd_ready); else pass_n++;
    tick();
    total_n++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp_valid); else pass_n++;
    total_n++; if (rsp_out !== 8'd7 || rsp_expected !== 8'd7) $display("FAIL add_values: got out=%h exp=%h want 07/07", rsp_out, rsp_expected); else pass_n++;
    total_n++; if (rsp_checked !== 1'b1 || rsp_error !== 1'b0) $display("FAIL add_flags: got chk=%b err=%b want 1/0", rsp_checked, rsp_error); else pass_n++;
    total_n++; if (pass_cnt !== 16'd1 || err_cnt !== 16'd0) $display("FAIL add_counters: got pass=%0d err=%0d want 1/0", pass_cnt, err_cnt); else pass_n++;
    handshake1();
    total_n++; if (dut_in1 !== 4'd4 || dut_opcode !== 2'b00) $display("FAIL add_drive_hold: got %0d op %b want 4 op 00", dut_in1, dut_opcode); else pass_n++;
  endtask

  task automatic test_sub();
    rst = 1'b1; tick(); rst = 1'b0;
    total_n++; if (pass_cnt !== 16'd0) $display("FAIL sub_counter_clear: got %0d want 0", pass_cnt); else pass_n++;
    accept1(4'd5, 4'd3, 2'b01);
    tick();
    total_n++; if (rsp_out !== 8'd2 || rsp_expected !== 8'd2 || rsp_error !== 1'b0) $display("FAIL sub_5_3: got out=%h exp=%h err=%b want 02/02/0", rsp_out, rsp_expected, rsp_error); else pass_n++;
    handshake1();
    accept1(4'd3, 4'd5, 2'b01);
    tick();
    total_n++; if (rsp_out !== 8'hFE || rsp_expected !== 8'hFE || rsp_error !== 1'b0) $display("FAIL sub_3_5: got out=%h exp=%h err=%b want fe/fe/0", rsp_out, rsp_expected, rsp_error); else pass_n++;
    total_n++; if (pass_cnt !== 16'd2 || err_cnt !== 16'd0) $display("FAIL sub_counters: got pass=%0d err=%0d want 2/0", pass_cnt, err_cnt); else pass_n++;
    handshake1();
  endtask

  task automatic test_fault();
    fault = 1'b1;
    accept1(4'd15, 4'd15, 2'b00);
    tick();
    fault = 1'b0;
    total_n++; if (rsp_expected !== 8'h1E || rsp_out !== 8'h1F) $display("FAIL fault_values: got out=%h exp=%h want 1f/1e", rsp_out, rsp_expected); else pass_n++;
    total_n++; if (rsp_error !== 1'b1 || rsp_checked !== 1'b1) $display("FAIL fault_flags: got err=%b chk=%b want 1/1", rsp_error, rsp_checked); else pass_n++;
    total_n++; if (err_cnt !== 16'd1 || pass_cnt !== 16'd2) $display("FAIL fault_counters: got pass=%0d err=%0d want 2/1", pass_cnt, err_cnt); else pass_n++;
    handshake1();
  endtask

  task automatic test_reserved_stall();
    accept1(4'd2, 4'd2, 2'b10);
    tick();
    total_n++; if (rsp_checked !== 1'b0 || rsp_error !== 1'b0 || rsp_expected !== 8'h00) $display("FAIL rsv_flags: got chk=%b err=%b exp=%h want 0/0/00", rsp_checked, rsp_error, rsp_expected); else pass_n++;
    // A competing command while busy must be ignored.
    cmd_in1 = 4'd9; cmd_in2 = 4'd9; cmd_opcode = 2'b00; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_n++; if (rsp_valid !== 1'b1 || rsp_out !== 8'h22 || cmd_ready !== 1'b0 || dut_in1 !== 4'd2) $display("FAIL rsv_stall_%0d: valid=%b out=%h ready=%b in1=%0d want 1/22/0/2", i, rsp_valid, rsp_out, cmd_ready, dut_in1); else pass_n++;
    end
    cmd_valid = 1'b0;
    total_n++; if (pass_cnt !== 16'd2 || err_cnt !== 16'd1) $display("FAIL rsv_counters: got pass=%0d err=%0d want 2/1", pass_cnt, err_cnt); else pass_n++;
    handshake1();
  endtask

  task automatic test_settle3_reset();
    cmd_in1 = 4'd1; cmd_in2 = 4'd1; cmd_opcode = 2'b00;
    cmd_valid_3 = 1'b1; tick(); cmd_valid_3 = 1'b0;
    tick(); tick();
    total_n++; if (rsp_valid_3 !== 1'b0 || busy_3 !== 1'b1) $display("FAIL s3_early: valid=%b busy=%b want 0/1", rsp_valid_3, busy_3); else pass_n++;
    tick();
    total_n++; if (rsp_valid_3 !== 1'b1 || rsp_out_3 !== 8'd2 || pass_cnt_3 !== 16'd1) $display("FAIL s3_capture: valid=%b out=%h pass=%0d want 1/02/1", rsp_valid_3, rsp_out_3, pass_cnt_3); else pass_n++;
    rsp_ready_3 = 1'b1; tick(); rsp_ready_3 = 1'b0;
    cmd_in1 = 4'd4; cmd_in2 = 4'd3;
    cmd_valid_3 = 1'b1; tick(); cmd_valid_3 = 1'b0;
    tick();
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    total_n++; if (rsp_valid_3 !== 1'b0 || cmd_ready_3 !== 1'b1 || busy_3 !== 1'b0) $display("FAIL s3_reset_state: valid=%b ready=%b busy=%b want 0/1/0", rsp_valid_3, cmd_ready_3, busy_3); else pass_n++;
    total_n++; if (pass_cnt_3 !== 16'd0 || err_cnt_3 !== 16'd0 || dut_in1_3 !== 4'd0) $display("FAIL s3_reset_clear: pass=%0d err=%0d in1=%0d want 0/0/0", pass_cnt_3, err_cnt_3, dut_in1_3); else pass_n++;
    tick(); tick();
    total_n++; if (rsp_valid_3 !== 1'b0 || cmd_ready_3 !== 1'b1) $display("FAIL s3_dropped: valid=%b ready=%b want 0/1", rsp_valid_3, cmd_ready_3); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_fault();
    test_reserved_stall();
    test_settle3_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
